// File: rtl/wdt_ctrl_regs.sv
// -----------------------------------------------------------------------------
// wdt_ctrl_regs
//   Memory-mapped control front-end for the watchdog timer core. It decodes
//   single-outstanding req/rsp bus transactions into the timer controls WDEN,
//   WDLIVE and WTOCNT. It also captures the timer's WTO output into a sticky
//   status bit that drives a level interrupt.
//
//   Register map (byte offsets):
//     0x00 CTRL    RW  {bit1 irq_en, bit0 WDEN}
//     0x04 LIVE    WO  any write pulses WDLIVE for LIVE_PULSE cycles, reads 0
//     0x08 WTOCNT  RW  timeout threshold, write rejected while WDEN=1
//     0x0C STATUS  W1C bit0 sticky WTO
//     0x10 KEY     only with WDT_KEY_EN (see below), otherwise unmapped
//
//   Optional feature macro: WDT_KEY_EN
//     When defined, CTRL and WTOCNT writes need a prior write of 0x5A5A_5A5A
//     to KEY. The unlock covers exactly the next accepted write. A locked or
//     wrong-key write returns rsp_err. Reading KEY returns {31'b0, unlocked}.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (accept when both high)
//   req_write/addr/wdata   request direction, byte offset, write data
//   rsp_valid/rsp_ready    response handshake (consumed when both high)
//   rsp_rdata/rsp_err      read data (0 for writes), error flag
//   WDEN/WDLIVE/WTOCNT     controls to the timer core
//   WTO                    timeout indication from the timer core
//   wto_irq                level interrupt = sticky WTO & irq_en
// -----------------------------------------------------------------------------
module wdt_ctrl_regs #(
  parameter int          ADDR_W     = 8,
  parameter int          LIVE_PULSE = 4,
  parameter logic [31:0] WTOCNT_RST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              WDEN,
  output logic              WDLIVE,
  output logic [31:0]       WTOCNT,
  input  logic              WTO,
  output logic              wto_irq
);

  localparam int                LIVE_W     = $clog2(LIVE_PULSE + 1);
  localparam logic [LIVE_W-1:0] LIVE_LOAD  = LIVE_W'(LIVE_PULSE);
  localparam logic [ADDR_W-1:0] OFS_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFS_LIVE   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFS_WTOCNT = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFS_STATUS = ADDR_W'(8'h0C);
`ifdef WDT_KEY_EN
  localparam logic [ADDR_W-1:0] OFS_KEY    = ADDR_W'(8'h10);
  localparam logic [31:0]       KEY_VALUE  = 32'h5A5A_5A5A;
`endif

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              wden_q, wden_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       wtocnt_q, wtocnt_d;
  logic              sticky_q, sticky_d;
  logic [LIVE_W-1:0] live_cnt_q, live_cnt_d;
  logic              wr_unlocked;

`ifdef WDT_KEY_EN
  logic              unlocked_q, unlocked_d;
  assign wr_unlocked = unlocked_q;
`else
  assign wr_unlocked = 1'b1;
`endif

  // Next-state logic. Register side effects commit on the accept edge.
  // Read data is captured from the pre-write register values at that edge.
  // A WTO seen in the same cycle as a W1C clear wins, so the clear is
  // OR-ed with WTO instead of overriding it.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wden_d      = wden_q;
    irq_en_d    = irq_en_q;
    wtocnt_d    = wtocnt_q;
    sticky_d    = sticky_q | WTO;
    live_cnt_d  = (live_cnt_q != '0) ? live_cnt_q - LIVE_W'(1) : '0;
`ifdef WDT_KEY_EN
    unlocked_d  = unlocked_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (req_write) begin
`ifdef WDT_KEY_EN
            unlocked_d = 1'b0;
`endif
            case (req_addr)
              OFS_CTRL: begin
                if (wr_unlocked) begin
                  wden_d   = req_wdata[0];
                  irq_en_d = req_wdata[1];
                end else begin
                  rsp_err_d = 1'b1;
                end
              end
              OFS_LIVE:   live_cnt_d = LIVE_LOAD;
              OFS_WTOCNT: begin
                // Threshold is locked while the timer runs.
                if (wr_unlocked && !wden_q) wtocnt_d  = req_wdata;
                else                        rsp_err_d = 1'b1;
              end
              OFS_STATUS: sticky_d = (sticky_q & ~req_wdata[0]) | WTO;
`ifdef WDT_KEY_EN
              OFS_KEY: begin
                if (req_wdata == KEY_VALUE) unlocked_d = 1'b1;
                else                        rsp_err_d  = 1'b1;
              end
`endif
              default:    rsp_err_d = 1'b1;
            endcase
          end else begin
            case (req_addr)
              OFS_CTRL:   rsp_rdata_d = {30'd0, irq_en_q, wden_q};
              OFS_LIVE:   rsp_rdata_d = '0;
              OFS_WTOCNT: rsp_rdata_d = wtocnt_q;
              OFS_STATUS: rsp_rdata_d = {31'd0, sticky_q};
`ifdef WDT_KEY_EN
              OFS_KEY:    rsp_rdata_d = {31'd0, unlocked_q};
`endif
              default:    rsp_err_d   = 1'b1;
            endcase
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset. A reset during RESP drops the
  // pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wden_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      wtocnt_q    <= WTOCNT_RST;
      sticky_q    <= 1'b0;
      live_cnt_q  <= '0;
`ifdef WDT_KEY_EN
      unlocked_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wden_q      <= wden_d;
      irq_en_q    <= irq_en_d;
      wtocnt_q    <= wtocnt_d;
      sticky_q    <= sticky_d;
      live_cnt_q  <= live_cnt_d;
`ifdef WDT_KEY_EN
      unlocked_q  <= unlocked_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign WDEN      = wden_q;
  assign WDLIVE    = (live_cnt_q != '0);
  assign WTOCNT    = wtocnt_q;
  assign wto_irq   = sticky_q & irq_en_q;

endmodule

// File: tb/tb_wdt_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_wdt_ctrl_regs
//   Self-checking bench for wdt_ctrl_regs. It uses a register-level reference
//   model of the map. WDLIVE is modelled as "high for LIVE_PULSE cycles after
//   the last LIVE accept". The bench honours WDT_KEY_EN when that macro is
//   defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wdt_ctrl_regs;

  localparam int          LIVE_PULSE = 4;
  localparam logic [31:0] KEY_VALUE  = 32'h5A5A_5A5A;
`ifdef WDT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        WDEN, WDLIVE, WTO, wto_irq;
  logic [31:0] WTOCNT;

  wdt_ctrl_regs #(.ADDR_W(8), .LIVE_PULSE(LIVE_PULSE), .WTOCNT_RST(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .WTO(WTO), .wto_irq(wto_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int live_high_total = 0;
  always @(negedge clk) if (WDLIVE === 1'b1) live_high_total <= live_high_total + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_wden, m_irq_en, m_sticky, m_unlocked;
  logic [31:0] m_wtocnt;
  int          m_live_last;

  logic [31:0] rd, erd;
  logic        er, eer;
  bit          to;

  task automatic model_reset();
    m_wden = 0; m_irq_en = 0; m_sticky = 0; m_unlocked = 0;
    m_wtocnt = 32'hFFFF_FFFF; m_live_last = -100;
  endtask

  // Applies one accepted transaction to the model and returns its response.
  task automatic model_access(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                              input bit wto, output logic [31:0] exp_rdata, output logic exp_err);
    bit may_write;
    may_write = KEY_EN ? m_unlocked : 1'b1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    if (wr) begin
      m_unlocked = 0;
      case (addr)
        8'h00: if (may_write) begin m_wden = data[0]; m_irq_en = data[1]; end else exp_err = 1;
        8'h04: m_live_last = cyc;
        8'h08: if (may_write && !m_wden) m_wtocnt = data; else exp_err = 1;
        8'h0C: if (data[0]) m_sticky = 0;
        8'h10: if (KEY_EN && data == KEY_VALUE) m_unlocked = 1; else exp_err = 1;
        default: exp_err = 1;
      endcase
    end else begin
      case (addr)
        8'h00: exp_rdata = {30'd0, m_irq_en, m_wden};
        8'h04: exp_rdata = '0;
        8'h08: exp_rdata = m_wtocnt;
        8'h0C: exp_rdata = {31'd0, m_sticky};
        8'h10: if (KEY_EN) exp_rdata = {31'd0, m_unlocked}; else exp_err = 1;
        default: exp_err = 1;
      endcase
    end
    if (wto) m_sticky = 1;
  endtask

  function automatic bit model_live();
    return (cyc >= m_live_last) && (cyc - m_live_last < LIVE_PULSE);
  endfunction

  // Runs one transaction, called and returning just after a falling edge.
  task automatic bus_txn(input bit wr, input logic [7:0] addr, input logic [31:0] data, input bit wto,
                         output logic [31:0] rdata, output logic err,
                         output logic [31:0] exp_rdata, output logic exp_err, output bit timeout);
    int n;
    timeout = 0; rdata = '0; err = 0; exp_rdata = '0; exp_err = 0;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = data; WTO = wto;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin timeout = 1; req_valid = 0; WTO = 0; return; end
    @(posedge clk); #1;
    model_access(wr, addr, data, wto, exp_rdata, exp_err);
    @(negedge clk);
    req_valid = 0; WTO = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin timeout = 1; return; end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic unlock();
    if (KEY_EN) bus_txn(1, 8'h10, KEY_VALUE, 0, rd, er, erd, eer, to);
  endtask

  task automatic apply_reset();
    rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0; WTO = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if ({WDEN, WDLIVE, wto_irq} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ctrl_outs: got %b expected 000", {WDEN, WDLIVE, wto_irq}); end
    n_checks++; if (WTOCNT !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL reset_wtocnt: got %h expected ffffffff", WTOCNT); end
  endtask

  task automatic test_regs();
    bus_txn(0, 8'h08, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (to || rd !== 32'hFFFF_FFFF || er !== 1'b0) begin n_fail++; $display("[TB] FAIL read_wtocnt_rst: got %h/%b to=%b expected ffffffff/0", rd, er, to); end
    bus_txn(0, 8'h00, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (to || rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("[TB] FAIL read_ctrl_rst: got %h/%b expected 0/0", rd, er); end
    unlock(); bus_txn(1, 8'h08, 100, 0, rd, er, erd, eer, to);
    n_checks++; if (to || er !== 1'b0) begin n_fail++; $display("[TB] FAIL write_wtocnt_100: err got %b expected 0", er); end
    unlock(); bus_txn(1, 8'h00, 1, 0, rd, er, erd, eer, to);
    n_checks++; if (WTOCNT !== 32'd100 || WDEN !== 1'b1) begin n_fail++; $display("[TB] FAIL enable: got WTOCNT=%0d WDEN=%b expected 100/1", WTOCNT, WDEN); end
    unlock(); bus_txn(1, 8'h08, 5, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b1 || WTOCNT !== 32'd100) begin n_fail++; $display("[TB] FAIL wtocnt_locked: got err=%b WTOCNT=%0d expected 1/100", er, WTOCNT); end
    bus_txn(0, 8'h10, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (to || er !== eer || rd !== erd) begin n_fail++; $display("[TB] FAIL read_key_ofs: got %h/%b expected %h/%b", rd, er, erd, eer); end
    unlock(); bus_txn(1, 8'h00, 0, 0, rd, er, erd, eer, to);
    unlock(); bus_txn(1, 8'h08, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b0 || WTOCNT !== 32'd0 || WDEN !== 1'b0) begin n_fail++; $display("[TB] FAIL wtocnt_zero: got err=%b WTOCNT=%0d WDEN=%b expected 0/0/0", er, WTOCNT, WDEN); end
    bus_txn(0, 8'h03, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL unaligned_err: got %b expected 1", er); end
    bus_txn(0, 8'h04, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("[TB] FAIL read_live: got %h/%b expected 0/0", rd, er); end
  endtask

  task automatic test_live();
    int s0;
    s0 = live_high_total;
    bus_txn(1, 8'h04, $urandom, 0, rd, er, erd, eer, to);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (WDLIVE !== model_live()) begin n_fail++; $display("[TB] FAIL live_single c%0d: got %b expected %b", i, WDLIVE, model_live()); end
      @(negedge clk);
    end
    n_checks++; if (live_high_total - s0 !== LIVE_PULSE) begin n_fail++; $display("[TB] FAIL live_width: got %0d expected %0d", live_high_total - s0, LIVE_PULSE); end
    s0 = live_high_total;
    bus_txn(1, 8'h04, $urandom, 0, rd, er, erd, eer, to);
    bus_txn(1, 8'h04, $urandom, 0, rd, er, erd, eer, to);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (WDLIVE !== model_live()) begin n_fail++; $display("[TB] FAIL live_rewrite c%0d: got %b expected %b", i, WDLIVE, model_live()); end
      @(negedge clk);
    end
    n_checks++; if (live_high_total - s0 !== LIVE_PULSE + 2) begin n_fail++; $display("[TB] FAIL live_restart_width: got %0d expected %0d", live_high_total - s0, LIVE_PULSE + 2); end
  endtask

  task automatic test_sticky();
    unlock(); bus_txn(1, 8'h00, 3, 0, rd, er, erd, eer, to);
    WTO = 1; @(negedge clk); WTO = 0; m_sticky = 1;
    n_checks++; if (wto_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_set: got %b expected 1", wto_irq); end
    bus_txn(1, 8'h0C, 1, 0, rd, er, erd, eer, to);
    n_checks++; if (wto_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_w1c: got %b expected 0", wto_irq); end
    bus_txn(0, 8'h0C, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL status_cleared: got %h expected 0", rd); end
    WTO = 1; @(negedge clk); WTO = 0; m_sticky = 1;
    bus_txn(1, 8'h0C, 1, 1, rd, er, erd, eer, to);
    n_checks++; if (wto_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL w1c_vs_wto: got %b expected 1", wto_irq); end
    unlock(); bus_txn(1, 8'h00, 0, 0, rd, er, erd, eer, to);
    bus_txn(0, 8'h0C, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (rd !== 32'h1 || wto_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL sticky_after_disable: got %h irq=%b expected 1/0", rd, wto_irq); end
    bus_txn(1, 8'h0C, 1, 0, rd, er, erd, eer, to);
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 1; req_write = 0; req_addr = 8'h08; req_wdata = '0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (n >= 20) begin n_fail++; $display("[TB] FAIL bp_accept_timeout: got no ready expected ready"); end
    @(posedge clk); #1;
    model_access(0, 8'h08, 0, 0, erd, eer);
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== erd || rsp_err !== eer)
        begin n_fail++; $display("[TB] FAIL bp_hold c%0d: got v=%b r=%b %h/%b expected 1/0 %h/%b", i, rsp_valid, req_ready, rsp_rdata, rsp_err, erd, eer); end
      @(negedge clk);
    end
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release: got v=%b r=%b expected 0/1", rsp_valid, req_ready); end
    bus_txn(0, 8'h20, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (to || er !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_0x20: got %b expected 1", er); end
  endtask

  task automatic test_reset_mid();
    unlock(); bus_txn(1, 8'h00, 3, 0, rd, er, erd, eer, to);
    req_valid = 1; req_write = 0; req_addr = 8'h00;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_inflight: got %b expected 1", rsp_valid); end
    rst = 1; @(negedge clk); rst = 0; model_reset();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || WDEN !== 1'b0 || rsp_rdata !== 32'h0)
      begin n_fail++; $display("[TB] FAIL mid_reset: got v=%b r=%b WDEN=%b rd=%h expected 0/1/0/0", rsp_valid, req_ready, WDEN, rsp_rdata); end
  endtask

`ifdef WDT_KEY_EN
  task automatic test_key();
    apply_reset();
    bus_txn(1, 8'h00, 1, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b1 || WDEN !== 1'b0) begin n_fail++; $display("[TB] FAIL key_locked: got err=%b WDEN=%b expected 1/0", er, WDEN); end
    bus_txn(1, 8'h10, 32'h1234_5678, 0, rd, er, erd, eer, to);
    bus_txn(0, 8'h10, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL key_wrong: got %h expected 0", rd); end
    bus_txn(1, 8'h10, KEY_VALUE, 0, rd, er, erd, eer, to);
    bus_txn(0, 8'h10, 0, 0, rd, er, erd, eer, to);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL key_unlocked: got %h expected 1", rd); end
    bus_txn(1, 8'h00, 1, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b0 || WDEN !== 1'b1) begin n_fail++; $display("[TB] FAIL key_write: got err=%b WDEN=%b expected 0/1", er, WDEN); end
    bus_txn(1, 8'h00, 3, 0, rd, er, erd, eer, to);
    n_checks++; if (er !== 1'b1 || wto_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL key_relock: got err=%b expected 1", er); end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  addr;
    logic [31:0] data;
    bit          wr, wto;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: addr = 8'h00;  1: addr = 8'h04;  2: addr = 8'h08;  3: addr = 8'h0C;
        4: addr = 8'h10;  5: addr = 8'h10;  6: addr = 8'h14;
        default: addr = 8'($urandom);
      endcase
      wr   = $urandom_range(0, 1);
      data = $urandom;
      if (addr == 8'h00) data = 32'($urandom_range(0, 3));
      if (addr == 8'h10 && $urandom_range(0, 3) != 0) data = KEY_VALUE;
      wto  = ($urandom_range(0, 3) == 0);
      bus_txn(wr, addr, data, wto, rd, er, erd, eer, to);
      n_checks++; if (to || rd !== erd || er !== eer)
        begin n_fail++; $display("[TB] FAIL rand_rsp #%0d wr=%b a=%h: got %h/%b expected %h/%b", i, wr, addr, rd, er, erd, eer); end
      n_checks++; if (WDEN !== m_wden || WTOCNT !== m_wtocnt || wto_irq !== (m_sticky & m_irq_en) || WDLIVE !== model_live())
        begin n_fail++; $display("[TB] FAIL rand_state #%0d: got %b %h %b %b expected %b %h %b %b", i, WDEN, WTOCNT, wto_irq, WDLIVE,
                                 m_wden, m_wtocnt, m_sticky & m_irq_en, model_live()); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_regs();
    test_live();
    test_sticky();
    test_backpressure();
`ifdef WDT_KEY_EN
    test_key();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
